// File: rtl/eth_tx_arb_pkg.sv
// Shared types and helpers for the TX frame arbiter and its round-robin picker.
package eth_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    // Bit of tuser that flags a damaged or truncated frame.
    localparam int ERR_BIT = 0;

    // Index width for a requester count; never narrower than one bit.
    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/eth_rr_pick.sv
// Rotate-priority encoder: returns the first set request found when searching
// upward from ptr+1 (mod NumReq). Purely combinational.
module eth_rr_pick
    import eth_tx_arb_pkg::*;
#(
    parameter int NumReq   = 2,
    parameter int IdxWidth = idx_width(NumReq)
) (
    input  logic [NumReq-1:0]   req,
    input  logic [IdxWidth-1:0] ptr,
    output logic [IdxWidth-1:0] idx,
    output logic                found
);

    logic [IdxWidth-1:0] cand;

    // Walk the requesters starting just after ptr; the first hit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NumReq; k++) begin
            cand = IdxWidth'((int'(ptr) + k) % NumReq);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding the RGMII framing TX stream.
// A grant is held from first beat to tlast; runaway frames are cut at MaxBeats,
// flagged in tuser[ERR_BIT], and the remainder of the source frame is drained.
// Optional: define ETH_TX_ARB_PRIO0_EN to give requester 0 strict priority.
module eth_tx_frame_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int NumReq    = 2,
    parameter int DataWidth = 8,
    parameter int UserWidth = 1,
    parameter int MaxBeats  = 1522,
    parameter int CntWidth  = $clog2(MaxBeats + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq*DataWidth-1:0]   s_tdata_i,
    input  logic [NumReq*UserWidth-1:0]   s_tuser_i,
    input  logic [NumReq-1:0]             s_tlast_i,
    input  logic [NumReq-1:0]             s_tvalid_i,
    output logic [NumReq-1:0]             s_tready_o,
    output logic [DataWidth-1:0]          m_tdata_o,
    output logic [UserWidth-1:0]          m_tuser_o,
    output logic                          m_tlast_o,
    output logic                          m_tvalid_o,
    input  logic                          m_tready_i,
    output logic                          gnt_valid_o,
    output logic [idx_width(NumReq)-1:0]  gnt_idx_o,
    output logic                          trunc_o
);

    localparam int IdxWidth = idx_width(NumReq);

    arb_state_e          state_q, state_d;
    logic [IdxWidth-1:0] rr_q, rr_d;
    logic [IdxWidth-1:0] gnt_q, gnt_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                trunc_q, trunc_d;

    logic [DataWidth-1:0] g_data;
    logic [UserWidth-1:0] g_user;
    logic                 g_last;
    logic                 g_valid;
    logic [NumReq-1:0]    gnt_oh;

    logic [NumReq-1:0]    rr_req;
    logic [IdxWidth-1:0]  pick_idx;
    logic                 pick_found;
    logic                 any_req;
    logic [IdxWidth-1:0]  new_gnt;
    logic [IdxWidth-1:0]  rr_end;

`ifdef ETH_TX_ARB_PRIO0_EN
    // Requester 0 bypasses the rotation and never moves the pointer.
    assign rr_req  = s_tvalid_i & {{(NumReq-1){1'b1}}, 1'b0};
    assign any_req = s_tvalid_i[0] | pick_found;
    assign new_gnt = s_tvalid_i[0] ? '0 : pick_idx;
    assign rr_end  = (gnt_q == '0) ? rr_q : gnt_q;
`else
    assign rr_req  = s_tvalid_i;
    assign any_req = pick_found;
    assign new_gnt = pick_idx;
    assign rr_end  = gnt_q;
`endif

    eth_rr_pick #(
        .NumReq   (NumReq),
        .IdxWidth (IdxWidth)
    ) u_pick (
        .req   (rr_req),
        .ptr   (rr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Select the granted requester's slice and build its one-hot ready mask.
    always_comb begin
        g_data  = '0;
        g_user  = '0;
        g_last  = 1'b0;
        g_valid = 1'b0;
        gnt_oh  = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (gnt_q == IdxWidth'(i)) begin
                g_data    = s_tdata_i[i*DataWidth +: DataWidth];
                g_user    = s_tuser_i[i*UserWidth +: UserWidth];
                g_last    = s_tlast_i[i];
                g_valid   = s_tvalid_i[i];
                gnt_oh[i] = 1'b1;
            end
        end
    end

    // Next-state logic and stream steering for IDLE / BUSY / DRAIN.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        trunc_d    = 1'b0;
        m_tvalid_o = 1'b0;
        m_tdata_o  = g_data;
        m_tuser_o  = g_user;
        m_tlast_o  = g_last;
        s_tready_o = '0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d   = new_gnt;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                m_tvalid_o = g_valid;
                s_tready_o = gnt_oh & {NumReq{m_tready_i}};
                if (g_valid && m_tready_i) begin
                    if (cnt_q != CntWidth'(MaxBeats)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (g_last) begin
                        rr_d    = rr_end;
                        state_d = IDLE;
                    end else if (cnt_q == CntWidth'(MaxBeats - 1)) begin
                        m_tlast_o          = 1'b1;
                        m_tuser_o[ERR_BIT] = 1'b1;
                        trunc_d            = 1'b1;
                        state_d            = DRAIN;
                    end
                end
            end
            DRAIN: begin
                s_tready_o = gnt_oh;
                if (g_valid && g_last) begin
                    rr_d    = rr_end;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt_valid_o = (state_q != IDLE);
    assign gnt_idx_o   = gnt_q;
    assign trunc_o     = trunc_q;

    // State, pointer, grant and beat counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= IdxWidth'(NumReq - 1);
            gnt_q   <= '0;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Scoreboard bench for eth_tx_frame_arbiter: randomized frames per source,
// expected output stream derived from frame-level arbitration rules.
// Honours ETH_TX_ARB_PRIO0_EN in its reference model.
module tb_eth_tx_frame_arbiter;

    localparam int NR = 3;
    localparam int DW = 8;
    localparam int UW = 2;
    localparam int MB = 64;
    localparam int IW = 2;
    localparam int BW = DW + UW + 2;
    localparam int EW = 1 + IW + 1 + UW + DW;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [NR*DW-1:0]  s_tdata;
    logic [NR*UW-1:0]  s_tuser;
    logic [NR-1:0]     s_tlast;
    logic [NR-1:0]     s_tvalid;
    logic [NR-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic [UW-1:0]     m_tuser;
    logic              m_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic              gnt_valid;
    logic [IW-1:0]     gnt_idx;
    logic              trunc;

    always #4 clk = ~clk;

    eth_tx_frame_arbiter #(
        .NumReq    (NR),
        .DataWidth (DW),
        .UserWidth (UW),
        .MaxBeats  (MB)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .s_tdata_i   (s_tdata),
        .s_tuser_i   (s_tuser),
        .s_tlast_i   (s_tlast),
        .s_tvalid_i  (s_tvalid),
        .s_tready_o  (s_tready),
        .m_tdata_o   (m_tdata),
        .m_tuser_o   (m_tuser),
        .m_tlast_o   (m_tlast),
        .m_tvalid_o  (m_tvalid),
        .m_tready_i  (m_tready),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx),
        .trunc_o     (trunc)
    );

    // Beat word: {first, last, user, data}
    logic [BW-1:0] src_q [NR][$];
    logic [BW-1:0] tmp_q [NR][$];
    int            plan_len [NR][$];
    // Expected word: {trunc, gnt, last, user, data}
    logic [EW-1:0] exp_q [$];

    int checks = 0;
    int failures = 0;
    int model_rr;
    int stall_left;
    int beats_seen = 0;
    bit gaps_en;
    bit stall_en;

    logic          snap_gv, snap_mv, snap_tr;
    logic [IW-1:0] snap_gi;
    logic [NR-1:0] snap_sr;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic finishTest();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    function automatic bit anySrc();
        for (int s = 0; s < NR; s++) if (src_q[s].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Present each source's queue head; first beats are always valid.
    task automatic driveOutputs();
        logic [BW-1:0] w;
        for (int s = 0; s < NR; s++) begin
            if (src_q[s].size() > 0) begin
                w = src_q[s][0];
                s_tvalid[s] = (w[BW-1] || !gaps_en) ? 1'b1 : ($urandom_range(0, 3) != 0);
                s_tdata[s*DW +: DW] = w[DW-1:0];
                s_tuser[s*UW +: UW] = w[DW+UW-1:DW];
                s_tlast[s] = w[BW-2];
            end else begin
                s_tvalid[s] = 1'b0;
                s_tdata[s*DW +: DW] = DW'($urandom);
                s_tuser[s*UW +: UW] = UW'($urandom);
                s_tlast[s] = 1'($urandom_range(0, 1));
            end
        end
        if (!stall_en) begin
            m_tready = 1'b1;
        end else if (stall_left > 0) begin
            m_tready = 1'b0;
            stall_left--;
        end else begin
            m_tready = 1'b1;
            if ($urandom_range(0, 15) == 0) stall_left = $urandom_range(0, 50);
        end
    endtask

    task automatic stepCycle();
        logic [NR-1:0] hs;
        @(negedge clk);
        hs      = s_tvalid & s_tready;
        snap_gv = gnt_valid;
        snap_gi = gnt_idx;
        snap_mv = m_tvalid;
        snap_sr = s_tready;
        snap_tr = trunc;
        @(posedge clk);
        #1;
        for (int s = 0; s < NR; s++)
            if (hs[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
        driveOutputs();
    endtask

    // Expected output beats of one source frame, cut at MB beats if it runs on.
    task automatic scheduleFrame(input int c);
        logic [BW-1:0] w;
        logic          last, tr;
        logic [UW-1:0] user;
        int k = 0;
        do begin
            w = tmp_q[c].pop_front();
            k++;
            if (k <= MB) begin
                last = w[BW-2];
                user = w[DW+UW-1:DW];
                tr   = 1'b0;
                if (k == MB && !last) begin
                    last    = 1'b1;
                    user[0] = 1'b1;
                    tr      = 1'b1;
                end
                exp_q.push_back({tr, IW'(c), last, user, w[DW-1:0]});
            end
        end while (!w[BW-2]);
    endtask

    // Build the planned frames and queue their beats in arbitration order.
    task automatic applyStimulus();
        int cnt [NR];
        int total = 0;
        int len, pick, c;
        for (int s = 0; s < NR; s++) begin
            cnt[s] = plan_len[s].size();
            total += cnt[s];
            while (plan_len[s].size() > 0) begin
                len = plan_len[s].pop_front();
                for (int k = 1; k <= len; k++) begin
                    src_q[s].push_back({k == 1, k == len, UW'($urandom), DW'($urandom)});
                    tmp_q[s].push_back(src_q[s][src_q[s].size()-1]);
                end
            end
        end
        while (total > 0) begin
            pick = -1;
`ifdef ETH_TX_ARB_PRIO0_EN
            if (cnt[0] > 0) pick = 0;
`endif
            for (int k = 1; k <= NR; k++) begin
                c = (model_rr + k) % NR;
`ifdef ETH_TX_ARB_PRIO0_EN
                if (c == 0) continue;
`endif
                if (pick < 0 && cnt[c] > 0) pick = c;
            end
`ifdef ETH_TX_ARB_PRIO0_EN
            if (pick != 0) model_rr = pick;
`else
            model_rr = pick;
`endif
            cnt[pick]--;
            total--;
            scheduleFrame(pick);
        end
        driveOutputs();
    endtask

    task automatic waitIdle(input int maxc, input string name);
        int n = 0;
        while (exp_q.size() > 0 || anySrc()) begin
            stepCycle();
            n++;
            if (n > maxc) begin
                checks++;
                failures++;
                $display("[TB] FAIL %s_timeout actual=%0d_beats_left required=0", name, exp_q.size());
                finishTest();
            end
        end
        repeat (2) stepCycle();
    endtask

    // Monitor: compares every output handshake and per-cycle rules.
    initial begin : monitor
        logic [EW-1:0] e;
        logic [NR-1:0] oh;
        bit exp_tr = 0, bubble_due = 0, idle_due = 0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                exp_tr = 0;
                bubble_due = 0;
                idle_due = 0;
            end else begin
                checkOutput("trunc_pulse", 32'(trunc), 32'(exp_tr));
                exp_tr = 0;
                if (idle_due) begin
                    checkOutput("regrant_after_bubble", 32'(gnt_valid), 32'(exp_q.size() > 0));
                    idle_due = 0;
                end
                if (bubble_due) begin
                    checkOutput("bubble_idle", 32'(gnt_valid), 32'd0);
                    bubble_due = 0;
                    idle_due = 1;
                end
                oh = NR'(1) << gnt_idx;
                if (!gnt_valid) checkOutput("ready_when_idle", 32'(s_tready), 32'd0);
                else            checkOutput("ready_others", 32'(s_tready & ~oh), 32'd0);
                if (m_tvalid) begin
                    checkOutput("ready_follows", 32'(s_tready[gnt_idx]), 32'(m_tready));
                    checkOutput("mvalid_has_grant", 32'(gnt_valid), 32'd1);
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_beat actual=0x%0h required=none",
                                 {gnt_idx, m_tlast, m_tuser, m_tdata});
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("beat", 32'({gnt_idx, m_tlast, m_tuser, m_tdata}), 32'(e[EW-2:0]));
                        exp_tr = e[EW-1];
                        if (e[DW+UW] && !e[EW-1]) bubble_due = 1;
                        beats_seen++;
                    end
                end
            end
        end
    end

    initial begin : main
        int base, n;
        rst_ni = 1'b0;
        gaps_en = 0;
        stall_en = 0;
        stall_left = 0;
        model_rr = NR - 1;
        s_tvalid = '0;
        s_tlast = '0;
        s_tdata = '0;
        s_tuser = '0;
        m_tready = 1'b1;
        driveOutputs();
        repeat (3) stepCycle();
        rst_ni = 1'b1;
        stepCycle();
        checkOutput("reset_gnt_valid", 32'(snap_gv), 32'd0);
        checkOutput("reset_gnt_idx", 32'(snap_gi), 32'd0);
        checkOutput("reset_m_tvalid", 32'(snap_mv), 32'd0);
        checkOutput("reset_s_tready", 32'(snap_sr), 32'd0);
        checkOutput("reset_trunc", 32'(snap_tr), 32'd0);

        $display("[TB] phase single source");
        plan_len[1].push_back(64);
        applyStimulus();
        stepCycle();
        checkOutput("arb_latency_idle", 32'(snap_mv), 32'd0);
        stepCycle();
        checkOutput("first_beat_valid", 32'(snap_mv), 32'd1);
        checkOutput("first_grant_idx", 32'(snap_gi), 32'd1);
        waitIdle(400, "single");

        $display("[TB] phase fairness");
        for (int s = 0; s < NR; s++) repeat (2) plan_len[s].push_back(10);
        applyStimulus();
        waitIdle(400, "fairness");

        $display("[TB] phase backpressure");
        stall_en = 1;
        gaps_en = 1;
        plan_len[0].push_back(70);
        applyStimulus();
        waitIdle(8000, "backpressure");

        $display("[TB] phase frame length boundaries");
        stall_en = 0;
        gaps_en = 0;
        plan_len[2].push_back(100);
        plan_len[0].push_back(64);
        plan_len[0].push_back(65);
        plan_len[1].push_back(1);
        applyStimulus();
        waitIdle(1000, "boundaries");

        $display("[TB] phase random traffic");
        stall_en = 1;
        gaps_en = 1;
        repeat (3) begin
            for (int s = 0; s < NR; s++) begin
                n = $urandom_range(0, 2);
                repeat (n) plan_len[s].push_back($urandom_range(1, 100));
            end
            applyStimulus();
            waitIdle(20000, "random");
        end

        $display("[TB] phase reset mid-frame");
        stall_en = 0;
        gaps_en = 0;
        plan_len[1].push_back(40);
        applyStimulus();
        base = beats_seen;
        n = 0;
        while (beats_seen - base < 20) begin
            stepCycle();
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("[TB] FAIL reset_phase_timeout actual=%0d_beats required=20", beats_seen - base);
                finishTest();
            end
        end
        rst_ni = 1'b0;
        for (int s = 0; s < NR; s++) src_q[s].delete();
        exp_q.delete();
        model_rr = NR - 1;
        driveOutputs();
        stepCycle();
        rst_ni = 1'b1;
        stepCycle();
        checkOutput("midreset_gnt_valid", 32'(snap_gv), 32'd0);
        checkOutput("midreset_gnt_idx", 32'(snap_gi), 32'd0);
        checkOutput("midreset_m_tvalid", 32'(snap_mv), 32'd0);
        checkOutput("midreset_s_tready", 32'(snap_sr), 32'd0);
        checkOutput("midreset_trunc", 32'(snap_tr), 32'd0);
        plan_len[0].push_back(5);
        plan_len[2].push_back(5);
        applyStimulus();
        waitIdle(200, "after_reset");

        $display("[TB] phase late requesters during busy frame");
        plan_len[1].push_back(30);
        applyStimulus();
        repeat (5) stepCycle();
        plan_len[0].push_back(4);
        plan_len[2].push_back(4);
        applyStimulus();
        waitIdle(300, "late_requesters");

        finishTest();
    end

endmodule
